// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes stage ahead of shiftRows.
// Substitutes SBOX_PER_CYCLE bytes per clock through shared S-box lookups.
// SBOX_PER_CYCLE must be 4, 8 or 16.
// Optional macro SUB_BYTES_INV_EN adds the 'inv' port and the inverse S-box.
module sub_bytes_iter #(
    parameter int unsigned SBOX_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:3][0:3][7:0]   state,
`ifdef SUB_BYTES_INV_EN
    input  logic                   inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:3][0:3][7:0]   o
);

    localparam int unsigned N_ITER = 16 / SBOX_PER_CYCLE;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // FIPS-197 forward S-box, entry 0 is the most significant byte
    localparam logic [0:255][7:0] SBOX_FWD = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_BYTES_INV_EN
    // FIPS-197 inverse S-box for the InvSubBytes path
    localparam logic [0:255][7:0] SBOX_INV = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    // One shared S-box instance, direction chosen by the stored inv flag
    function automatic logic [7:0] f_sub(input logic [7:0] x, input logic sel_inv);
        return sel_inv ? SBOX_INV[x] : SBOX_FWD[x];
    endfunction
`else
    // One shared S-box instance, forward only
    function automatic logic [7:0] f_sub(input logic [7:0] x);
        return SBOX_FWD[x];
    endfunction
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [0:15][7:0]  r_buf;      // linear byte index = col*4 + row
    logic [0:15][7:0]  w_buf_nxt;
    logic [3:0]        w_base;
`ifdef SUB_BYTES_INV_EN
    logic              r_inv;
    logic              w_inv_nxt;
`endif

    // First byte of the chunk handled this cycle
    assign w_base = 4'(r_cnt * SBOX_PER_CYCLE);

    // Next-state, counter and buffer update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
`ifdef SUB_BYTES_INV_EN
        w_inv_nxt   = r_inv;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_buf_nxt   = state;
                    w_cnt_nxt   = '0;
`ifdef SUB_BYTES_INV_EN
                    w_inv_nxt   = inv;
`endif
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int j = 0; j < int'(SBOX_PER_CYCLE); j++) begin
`ifdef SUB_BYTES_INV_EN
                    w_buf_nxt[w_base + 4'(j)] = f_sub(r_buf[w_base + 4'(j)], r_inv);
`else
                    w_buf_nxt[w_base + 4'(j)] = f_sub(r_buf[w_base + 4'(j)]);
`endif
                end
                if (r_cnt == CNT_W'(N_ITER - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and buffer registers; reset discards any in-flight state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
`ifdef SUB_BYTES_INV_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
`ifdef SUB_BYTES_INV_EN
            r_inv   <= w_inv_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign o         = r_buf;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Testbench for sub_bytes_iter: S-box reference built from GF(2^8) arithmetic.
// Define SUB_BYTES_INV_EN for both files to exercise the inverse path.
module tb_sub_bytes_iter;

    localparam int unsigned SPC    = 4;
    localparam int unsigned N_ITER = 16 / SPC;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [0:3][0:3][7:0]  state_i;
    logic                  inv_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [0:3][0:3][7:0]  o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    sub_bytes_iter #(.SBOX_PER_CYCLE(SPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state_i),
`ifdef SUB_BYTES_INV_EN
        .inv       (inv_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    always #5 clk = ~clk;

    // Compare and count
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_def(input logic [7:0] x);
        logic [7:0]  r = 8'h01;
        logic [15:0] t;
        if (x == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, x);
        t = {r, r};
        return r ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = st[127-8*i -: 8];
            r[127-8*i -: 8] = inv ? inv_t[b] : fwd_t[b];
        end
        return r;
    endfunction

    // One full transaction: accept, wait, optional backpressure, output handshake
    task automatic run_state(input string tag, input logic [127:0] st, input logic inv,
                             input int bp, input logic [127:0] exp);
        int n;
        @(negedge clk);
        chk({tag, ":in_ready"}, 128'(in_ready), 128'(1));
        state_i   = st;
        in_valid  = 1'b1;
        inv_i     = inv;
        out_ready = (bp == 0);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid) begin
                in_valid = 1'($urandom);
                state_i  = {$urandom, $urandom, $urandom, $urandom};
                inv_i    = 1'($urandom);
            end
        end while (!out_valid && n < 40);
        in_valid = 1'b0;
        chk({tag, ":latency"}, 128'(n - 1), 128'(N_ITER));
        chk({tag, ":o"}, o, exp);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            state_i  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk({tag, ":bp_out_valid"}, 128'(out_valid), 128'(1));
            chk({tag, ":bp_in_ready"}, 128'(in_ready), 128'(0));
            chk({tag, ":bp_o"}, o, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ":post_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, ":post_in_ready"}, 128'(in_ready), 128'(1));
        chk({tag, ":post_o_hold"}, o, exp);
    endtask

    initial begin
        logic [127:0] st;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inv_i     = 1'b0;
        state_i   = '0;

        for (int x = 0; x < 256; x++) fwd_t[x] = sbox_def(8'(x));
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_o", o, 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        #20;
        @(negedge clk);
        rst = 1'b1;

        run_state("zeros", 128'(0), 1'b0, 0, {16{8'h63}});
        run_state("fips_b", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0,
                  128'hd42711aee0bf98f1b8b45de51e415230);
        run_state("bp10", 128'h00112233445566778899aabbccddeeff, 1'b0, 10,
                  ref_sub(128'h00112233445566778899aabbccddeeff, 1'b0));

        // Abort mid-BUSY with asynchronous reset
        @(negedge clk);
        state_i  = {16{8'h53}};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_o", o, 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        run_state("after_abort", {16{8'hff}}, 1'b0, 0, {16{8'h16}});

        // Every byte value passes through the S-box at least once
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = 8'(k * 16 + i);
            run_state("sweep", st, 1'b0, k % 3, ref_sub(st, 1'b0));
        end

        for (int k = 0; k < 20; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_state("rand", st, 1'b0, int'($urandom_range(0, 3)), ref_sub(st, 1'b0));
        end

`ifdef SUB_BYTES_INV_EN
        run_state("inv63", {16{8'h63}}, 1'b1, 0, 128'(0));
        run_state("inv_fips_b", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 2,
                  128'h193de3bea0f4e22b9ac68d2ae9f84808);
        for (int k = 0; k < 10; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_state("rand_inv", st, 1'b1, int'($urandom_range(0, 3)), ref_sub(st, 1'b1));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
